move_cmd_queue: RTL and testbench
=================================

# move_cmd_queue

Turns keyboard scan events and board buttons into a queue of discrete player commands (step up/down/left/right, special attack) with hold-to-repeat. Sits between `KeyboardDecoder`/`debounce` and `player`/`player_attack`, replacing level-based key sensing. Each accepted command is delivered exactly once over a valid/ready handshake.

## Interface
Parameters:
- `REPEAT_DELAY`, default 50_000_000: cycles a direction must stay held before its first auto-repeat (0.5 s at 100 MHz).
- `REPEAT_PERIOD`, default 15_000_000: cycles between later auto-repeats.
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `key_valid` in 1: one-cycle strobe from `KeyboardDecoder`.
- `last_change` in 9: scan code of the latest key event.
- `key_down` in 512: key level vector.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced button levels; asynchronous to `clk`.
- `cmd_valid` out 1: the FIFO head is available.
- `cmd_code` out 3: FIFO head. Codes: 0 up, 1 down, 2 left, 3 right, 4 special.
- `cmd_ready` in 1: consumer accepts the head.
- `fifo_level` out log2(FIFO_DEPTH)+1: current occupancy.
- `drop_cnt` out 8: count of dropped commands; saturates at 255.

## Operation
- Buttons pass through a 2-flop synchronizer.
- Direction level: `dir_act[d]` = `key_down[code_d]` OR synced `btn_d`. Scan codes: up 0x075, down 0x072, left 0x06B, right 0x074.
- Press edge: `dir_act & ~dir_act_q`, where `dir_act_q` is registered every cycle.
- Special: `key_valid && last_change==0x069 && key_down[0x069]`. It never repeats.
- Push arbitration, at most one push per cycle, in priority order: special, pending, up, down, left, right.
  - A direction edge that loses to special is stored in a 1-deep `pending` register and pushed next cycle.
  - Other edges that lose in the same cycle are discarded. They do not count as drops.
- Repeat FSM states:
  - IDLE: on a pushed direction edge, latch `held_dir`, clear the timer, go to DELAY.
  - DELAY: when the timer reaches REPEAT_DELAY-1, emit a repeat, clear the timer, go to PERIOD.
  - PERIOD: when the timer reaches REPEAT_PERIOD-1, emit a repeat and clear the timer.
  - From DELAY or PERIOD: if `dir_act[held_dir]` falls, go to IDLE. A new direction edge re-latches `held_dir` and returns to DELAY.
- A repeat is pushed only if the FIFO is empty and there is no higher-priority push that cycle. Otherwise it is silently skipped; the timer still reloads and nothing is counted.
- FIFO full, with no pop that cycle:
  - An edge or special push is dropped and `drop_cnt` increments (saturating).
  - Push and pop in the same cycle while full are both accepted.
- Pop happens when `cmd_valid && cmd_ready`. `cmd_code` holds stable while valid and not ready. `cmd_code` is don't-care when `cmd_valid`=0 but is driven from the head slot; no X.
- Reset, mid-operation: FIFO empties, FSM goes to IDLE, `pending` clears, `dir_act_q` goes to 0.
  - A key still held after reset therefore produces a new edge on the first cycle out of reset.

## Timing
- Reset values: `cmd_valid`=0, `cmd_code`=0, `fifo_level`=0, `drop_cnt`=0.
- Keyboard path: level change before edge k is pushed at edge k; `cmd_valid`=1 after edge k when the FIFO was empty. Latency is 1 cycle.
- Button path: latency 3 cycles, synchronizer plus push.
- Deferred pending push: 1 cycle after the special push.
- First repeat follows the original push by REPEAT_DELAY cycles; later repeats every REPEAT_PERIOD cycles.
- Timer width: ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD))) bits, unsigned.

## Structure
- Package `move_cmd_pkg`:
  - command code constants (CMD_UP..CMD_SPECIAL);
  - scan code constants (SC_UP 9'h075, SC_DOWN 9'h072, SC_LEFT 9'h06B, SC_RIGHT 9'h074, SC_SPECIAL 9'h069);
  - repeat FSM state encoding.
- Sub-module `cmd_fifo`: synchronous FIFO, width 3, depth FIFO_DEPTH, with occupancy counter, full/empty flags and simultaneous push+pop. Reset is the same `rst`.

## Test plan
Bench uses REPEAT_DELAY=20, REPEAT_PERIOD=5, FIFO_DEPTH=4.
- Press at cycle 10: `key_down[0x075]`=1, `key_valid` pulse, `cmd_ready`=1. Then `cmd_valid`=1 for one cycle at cycle 11 with `cmd_code`=0.
- Hold 0x074 for 40 cycles with `cmd_ready`=1. Then commands 3 arrive at t0, t0+20, t0+25, t0+30, t0+35; no repeat after release.
- Special and up edges in the same cycle. Then `cmd_code` 4 is pushed, then 0 one cycle later; `fifo_level` reaches 2 with `cmd_ready`=0.
- `cmd_ready`=0 and 6 distinct edge presses. Then `fifo_level`=4 and `drop_cnt`=2; draining yields the first four codes in order.
- Hold left with `cmd_ready`=0 after one push. Then no repeats are enqueued (FIFO not empty) and `drop_cnt` stays 0.
- Assert `rst` mid-hold with the FIFO holding 3 entries. Then all outputs read 0 immediately; after release, the held key re-pushes its code in the first cycle.

Source files
------------

// File: rtl/move_cmd_pkg.sv
// Shared constants for the move command queue: command codes, PS/2 scan codes
// and the hold-to-repeat state encoding.
package move_cmd_pkg;

    localparam logic [2:0] CMD_UP      = 3'd0;
    localparam logic [2:0] CMD_DOWN    = 3'd1;
    localparam logic [2:0] CMD_LEFT    = 3'd2;
    localparam logic [2:0] CMD_RIGHT   = 3'd3;
    localparam logic [2:0] CMD_SPECIAL = 3'd4;

    localparam logic [8:0] SC_UP      = 9'h075;
    localparam logic [8:0] SC_DOWN    = 9'h072;
    localparam logic [8:0] SC_LEFT    = 9'h06B;
    localparam logic [8:0] SC_RIGHT   = 9'h074;
    localparam logic [8:0] SC_SPECIAL = 9'h069;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_PERIOD = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of 3-bit command codes with occupancy count and
// simultaneous push/pop (push into a full FIFO is accepted when a pop frees a slot).
module cmd_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [2:0]                    push_data,
    input  logic                          pop,
    output logic [2:0]                    head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          empty,
    output logic                          full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_acc;
    logic          pop_acc;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign head     = mem[rd_ptr];
    assign level    = count;

    // Storage is cleared too so the head slot never shows X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 3'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/move_cmd_queue.sv
// Converts key/button levels into discrete move commands with hold-to-repeat,
// queued in a small FIFO and handed out over valid/ready.
module move_cmd_queue
    import move_cmd_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 15_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [8:0]                    last_change,
    input  logic [511:0]                  key_down,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_code,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [3:0]  btn_sync_p0, btn_sync_p1;
    logic [3:0]  dir_act, dir_act_q, dir_edge;
    logic        special, edge_any;
    logic [1:0]  edge_dir;
    logic        pend_vld;
    logic [1:0]  pend_dir;
    rpt_state_t  state;
    logic [TW-1:0] timer;
    logic [1:0]  held_dir;
    logic        rpt_fire;
    logic        push_req, push_counted, dir_win, pend_load, drop, pop;
    logic [2:0]  push_code;
    logic [1:0]  win_dir;
    logic        fifo_empty, fifo_full;
    logic        unused_keys;

    assign unused_keys = ^key_down;

    // Stage p0/p1: two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
            dir_act_q   <= '0;
        end else begin
            btn_sync_p0 <= {btn_right, btn_left, btn_down, btn_up};
            btn_sync_p1 <= btn_sync_p0;
            dir_act_q   <= dir_act;
        end
    end

    always_comb begin
        dir_act[0] = key_down[SC_UP]    | btn_sync_p1[0];
        dir_act[1] = key_down[SC_DOWN]  | btn_sync_p1[1];
        dir_act[2] = key_down[SC_LEFT]  | btn_sync_p1[2];
        dir_act[3] = key_down[SC_RIGHT] | btn_sync_p1[3];
        dir_edge   = dir_act & ~dir_act_q;
        edge_any   = |dir_edge;
        if      (dir_edge[0]) edge_dir = CMD_UP[1:0];
        else if (dir_edge[1]) edge_dir = CMD_DOWN[1:0];
        else if (dir_edge[2]) edge_dir = CMD_LEFT[1:0];
        else                  edge_dir = CMD_RIGHT[1:0];
    end

    assign special = key_valid && (last_change == SC_SPECIAL) && key_down[SC_SPECIAL];
    assign rpt_fire = dir_act[held_dir] &&
                      (((state == RPT_DELAY)  && (timer == DELAY_LAST)) ||
                       ((state == RPT_PERIOD) && (timer == PERIOD_LAST)));

    // Single push per cycle: special > pending > edges > repeat (only into an empty FIFO).
    always_comb begin
        push_req     = 1'b0;
        push_code    = 3'd0;
        push_counted = 1'b0;
        dir_win      = 1'b0;
        win_dir      = 2'd0;
        pend_load    = 1'b0;
        if (special) begin
            push_req     = 1'b1;
            push_code    = CMD_SPECIAL;
            push_counted = 1'b1;
            pend_load    = edge_any && !pend_vld;
        end else if (pend_vld) begin
            push_req     = 1'b1;
            push_code    = {1'b0, pend_dir};
            push_counted = 1'b1;
            dir_win      = 1'b1;
            win_dir      = pend_dir;
        end else if (edge_any) begin
            push_req     = 1'b1;
            push_code    = {1'b0, edge_dir};
            push_counted = 1'b1;
            dir_win      = 1'b1;
            win_dir      = edge_dir;
        end else if (rpt_fire && fifo_empty) begin
            push_req     = 1'b1;
            push_code    = {1'b0, held_dir};
        end
    end

    assign cmd_valid = !fifo_empty;
    assign pop       = cmd_valid && cmd_ready;
    assign drop      = push_req && push_counted && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_dir <= 2'd0;
            drop_cnt <= 8'd0;
            state    <= RPT_IDLE;
            timer    <= '0;
            held_dir <= 2'd0;
        end else begin
            if (pend_load) begin
                pend_vld <= 1'b1;
                pend_dir <= edge_dir;
            end else if (!special) begin
                pend_vld <= 1'b0;
            end
            if (drop) drop_cnt <= sat_inc8(drop_cnt);
            if (dir_win) begin
                held_dir <= win_dir;
                timer    <= '0;
                state    <= RPT_DELAY;
            end else if (state != RPT_IDLE) begin
                if (!dir_act[held_dir]) begin
                    state <= RPT_IDLE;
                end else if (rpt_fire) begin
                    timer <= '0;
                    state <= RPT_PERIOD;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_code),
        .pop       (pop),
        .head      (cmd_code),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench for move_cmd_queue with short repeat timings.
module tb_move_cmd_queue;
    import move_cmd_pkg::*;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         btn_up, btn_down, btn_left, btn_right;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic         cmd_ready;
    logic [2:0]   fifo_level;
    logic [7:0]   drop_cnt;

    int tests  = 0;
    int failed = 0;

    move_cmd_queue #(.REPEAT_DELAY(20), .REPEAT_PERIOD(5), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ready   (cmd_ready),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       press;
        logic [8:0] sc;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [2:0] exp_level;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int exp_t[5];
        int nhit;
        int max_lvl;

        // Full-FIFO drop sequence followed by an in-order drain.
        vecs[0]  = '{1'b1, SC_UP,    1'b0, 1'b1, 3'd0, 3'd1, 8'd0};
        vecs[1]  = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd1, 8'd0};
        vecs[2]  = '{1'b1, SC_DOWN,  1'b0, 1'b1, 3'd0, 3'd2, 8'd0};
        vecs[3]  = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd2, 8'd0};
        vecs[4]  = '{1'b1, SC_LEFT,  1'b0, 1'b1, 3'd0, 3'd3, 8'd0};
        vecs[5]  = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd3, 8'd0};
        vecs[6]  = '{1'b1, SC_RIGHT, 1'b0, 1'b1, 3'd0, 3'd4, 8'd0};
        vecs[7]  = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd4, 8'd0};
        vecs[8]  = '{1'b1, SC_UP,    1'b0, 1'b1, 3'd0, 3'd4, 8'd1};
        vecs[9]  = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd4, 8'd1};
        vecs[10] = '{1'b1, SC_DOWN,  1'b0, 1'b1, 3'd0, 3'd4, 8'd2};
        vecs[11] = '{1'b0, 9'd0,     1'b0, 1'b1, 3'd0, 3'd4, 8'd2};
        vecs[12] = '{1'b0, 9'd0,     1'b1, 1'b1, 3'd1, 3'd3, 8'd2};
        vecs[13] = '{1'b0, 9'd0,     1'b1, 1'b1, 3'd2, 3'd2, 8'd2};
        vecs[14] = '{1'b0, 9'd0,     1'b1, 1'b1, 3'd3, 3'd1, 8'd2};
        vecs[15] = '{1'b0, 9'd0,     1'b1, 1'b0, 3'd0, 3'd0, 8'd2};

        rst = 1'b1; key_valid = 1'b0; last_change = '0; key_down = '0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        cmd_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // Single keyboard press around cycle 10.
        repeat (8) tick();
        cmd_ready = 1'b1;
        key_down[SC_UP] = 1'b1; last_change = SC_UP; key_valid = 1'b1;
        tick();
        chk("press_valid", cmd_valid, 1);
        chk("press_code", cmd_code, CMD_UP);
        key_valid = 1'b0; key_down[SC_UP] = 1'b0;
        tick();
        chk("press_once", cmd_valid, 0);
        repeat (3) tick();

        // Button path: synchronizer plus push gives three cycles.
        btn_down = 1'b1;
        tick();
        chk("btn_lat1", cmd_valid, 0);
        tick();
        chk("btn_lat2", cmd_valid, 0);
        tick();
        chk("btn_lat3", cmd_valid, 1);
        chk("btn_code", cmd_code, CMD_DOWN);
        btn_down = 1'b0;
        repeat (6) tick();
        chk("btn_once", cmd_valid, 0);

        // Hold right: original push then repeats at +20, +25, +30, +35.
        exp_t = '{0, 20, 25, 30, 35};
        nhit = 0;
        key_down[SC_RIGHT] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cmd_valid) begin
                chk("rpt_code", cmd_code, CMD_RIGHT);
                if (nhit < 5) chk("rpt_time", i, exp_t[nhit]);
                nhit++;
            end
            if (i == 39) key_down[SC_RIGHT] = 1'b0;
        end
        chk("rpt_count", nhit, 5);

        // Special and up edge in the same cycle.
        cmd_ready = 1'b0;
        last_change = SC_SPECIAL; key_valid = 1'b1;
        key_down[SC_SPECIAL] = 1'b1; key_down[SC_UP] = 1'b1;
        tick();
        chk("spec_code", cmd_code, CMD_SPECIAL);
        chk("spec_level1", fifo_level, 1);
        key_valid = 1'b0;
        tick();
        chk("spec_level2", fifo_level, 2);
        key_down = '0;
        cmd_ready = 1'b1;
        tick();
        chk("spec_pend_code", cmd_code, CMD_UP);
        chk("spec_pend_level", fifo_level, 1);
        tick();
        chk("spec_drained", fifo_level, 0);
        cmd_ready = 1'b0;
        repeat (2) tick();

        // Hold left behind a queued command: repeats must be skipped.
        key_down[SC_UP] = 1'b1;
        tick();
        key_down[SC_UP] = 1'b0;
        key_down[SC_LEFT] = 1'b1;
        tick();
        chk("hold_level", fifo_level, 2);
        max_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        chk("hold_no_rpt", max_lvl, 2);
        chk("hold_drop", drop_cnt, 0);
        key_down[SC_LEFT] = 1'b0;
        cmd_ready = 1'b1;
        tick();
        chk("hold_head", cmd_code, CMD_LEFT);
        tick();
        chk("hold_drained", fifo_level, 0);
        cmd_ready = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 16; v++) begin
            key_down = '0;
            if (vecs[v].press) key_down[vecs[v].sc] = 1'b1;
            cmd_ready = vecs[v].ready;
            tick();
            chk($sformatf("vec%0d_valid", v), cmd_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) chk($sformatf("vec%0d_code", v), cmd_code, vecs[v].exp_code);
            chk($sformatf("vec%0d_level", v), fifo_level, vecs[v].exp_level);
            chk($sformatf("vec%0d_drop", v), drop_cnt, vecs[v].exp_drop);
        end
        key_down = '0;
        cmd_ready = 1'b0;
        repeat (2) tick();

        // Reset mid-hold with three entries queued.
        key_down[SC_UP] = 1'b1;   tick(); key_down[SC_UP] = 1'b0;   tick();
        key_down[SC_DOWN] = 1'b1; tick(); key_down[SC_DOWN] = 1'b0; tick();
        key_down[SC_LEFT] = 1'b1; tick();
        chk("mid_level", fifo_level, 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_code", cmd_code, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_valid", cmd_valid, 1);
        chk("post_rst_code", cmd_code, CMD_LEFT);
        chk("post_rst_level", fifo_level, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
